// File: rtl/uart_pkg.sv
// Shared constants and types for the UART console transmit path.
package uart_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned DIGIT_W        = 6;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned FRAME_LEN_CRLF = 10;
    localparam int unsigned FRAME_LEN_BARE = 8;

    localparam logic [DATA_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [DATA_W-1:0] ASCII_COLON = 8'h3A;
    localparam logic [DATA_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [DATA_W-1:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_ECHO = 3'd1,
        ST_ISSUE_RPT  = 3'd2,
        ST_WAIT       = 3'd3,
        ST_GAP        = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] tens;
        logic [DATA_W-1:0] ones;
    } ascii_pair_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between the transmit scheduler and the UART TX core.
interface uart_tx_sched_if;
    import uart_pkg::*;

    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;

    modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);

endinterface

// File: rtl/bin2ascii2.sv
// Splits a 0..63 value into two ASCII decimal digits using repeated subtraction.
module bin2ascii2
    import uart_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output ascii_pair_t        digits_c
);

    logic [DIGIT_W-1:0] rem;
    logic [3:0]         tens;

    always_comb begin
        rem  = value;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        digits_c.tens = ASCII_ZERO + 8'(tens);
        digits_c.ones = ASCII_ZERO + 8'(rem);
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a receive echo and an atomic HH:MM:SS time report.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter bit ECHO_EN = 1'b1,
    parameter bit CRLF_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_done,
    input  logic               report_req,
    input  logic [4:0]         hour,
    input  logic [DIGIT_W-1:0] min,
    input  logic [DIGIT_W-1:0] sec,
    uart_tx_sched_if.master    tx,
    output logic               sched_busy,
    output logic               echo_drop,
    output logic               report_drop
);

    localparam int unsigned      FRAME_LEN = CRLF_EN ? FRAME_LEN_CRLF : FRAME_LEN_BARE;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    sched_state_e       state, next_state;
    logic               echo_valid, report_pend, in_frame;
    logic [DATA_W-1:0]  echo_byte;
    logic [IDX_W-1:0]   idx, idx_sel;
    logic [4:0]         snap_hour;
    logic [DIGIT_W-1:0] snap_min, snap_sec;
    logic [DIGIT_W-1:0] conv_hour, conv_min, conv_sec;
    ascii_pair_t        hour_c, min_c, sec_c;
    logic [DATA_W-1:0]  frame_byte_c;
    logic               echo_take, rpt_take;
    logic               tx_start_q, tx_start_nxt;
    logic [DATA_W-1:0]  tx_data_q, tx_data_nxt;
    logic               sched_busy_nxt, echo_drop_nxt, report_drop_nxt;

    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (!tx.tx_busy) begin
                    if (echo_valid)       next_state = ST_ISSUE_ECHO;
                    else if (report_pend) next_state = ST_ISSUE_RPT;
                end
            end
            ST_ISSUE_ECHO, ST_ISSUE_RPT: next_state = ST_WAIT;
            ST_WAIT: begin
                if (tx.tx_done) next_state = (in_frame && idx < LAST_IDX) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (!tx.tx_busy) next_state = ST_ISSUE_RPT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign echo_take = (state == ST_IDLE) && (next_state == ST_ISSUE_ECHO);
    assign rpt_take  = (state == ST_IDLE) && (next_state == ST_ISSUE_RPT);

    // The first frame byte is issued on the snapshot edge, so convert live time while idle.
    assign conv_hour = (state == ST_IDLE) ? {1'b0, hour} : {1'b0, snap_hour};
    assign conv_min  = (state == ST_IDLE) ? min : snap_min;
    assign conv_sec  = (state == ST_IDLE) ? sec : snap_sec;
    assign idx_sel   = (state == ST_IDLE) ? '0 : idx;

    bin2ascii2 u_hour (.value(conv_hour), .digits_c(hour_c));
    bin2ascii2 u_min  (.value(conv_min),  .digits_c(min_c));
    bin2ascii2 u_sec  (.value(conv_sec),  .digits_c(sec_c));

    always_comb begin
        frame_byte_c = ASCII_LF;
        case (idx_sel)
            4'd0:    frame_byte_c = hour_c.tens;
            4'd1:    frame_byte_c = hour_c.ones;
            4'd2:    frame_byte_c = ASCII_COLON;
            4'd3:    frame_byte_c = min_c.tens;
            4'd4:    frame_byte_c = min_c.ones;
            4'd5:    frame_byte_c = ASCII_COLON;
            4'd6:    frame_byte_c = sec_c.tens;
            4'd7:    frame_byte_c = sec_c.ones;
            4'd8:    frame_byte_c = ASCII_CR;
            default: frame_byte_c = ASCII_LF;
        endcase
    end

    always_comb begin
        tx_start_nxt    = 1'b0;
        tx_data_nxt     = tx_data_q;
        sched_busy_nxt  = (next_state != ST_IDLE);
        echo_drop_nxt   = ECHO_EN && rx_done && echo_valid && !echo_take;
        report_drop_nxt = report_req && report_pend && !rpt_take;
        unique case (next_state)
            ST_ISSUE_ECHO: begin
                tx_start_nxt = 1'b1;
                tx_data_nxt  = echo_byte;
            end
            ST_ISSUE_RPT: begin
                tx_start_nxt = 1'b1;
                tx_data_nxt  = frame_byte_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            sched_busy  <= 1'b0;
            echo_drop   <= 1'b0;
            report_drop <= 1'b0;
        end else begin
            tx_start_q  <= tx_start_nxt;
            tx_data_q   <= tx_data_nxt;
            sched_busy  <= sched_busy_nxt;
            echo_drop   <= echo_drop_nxt;
            report_drop <= report_drop_nxt;
        end
    end

    // Echo buffer, report flag, frame index and time snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_valid  <= 1'b0;
            echo_byte   <= '0;
            report_pend <= 1'b0;
            in_frame    <= 1'b0;
            idx         <= '0;
            snap_hour   <= '0;
            snap_min    <= '0;
            snap_sec    <= '0;
        end else begin
            if (ECHO_EN && rx_done) begin
                echo_byte  <= rx_data;
                echo_valid <= 1'b1;
            end else if (echo_take) begin
                echo_valid <= 1'b0;
            end

            if (report_req)    report_pend <= 1'b1;
            else if (rpt_take) report_pend <= 1'b0;

            if (rpt_take) begin
                snap_hour <= hour;
                snap_min  <= min;
                snap_sec  <= sec;
                idx       <= '0;
                in_frame  <= 1'b1;
            end else if (state == ST_WAIT && next_state == ST_GAP) begin
                idx <= idx + IDX_W'(1);
            end else if (state == ST_WAIT && next_state == ST_IDLE) begin
                in_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a cycle-level TX core model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int unsigned BYTE_CYC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_done, report_req;
    logic [4:0]  hour;
    logic [5:0]  min, sec;
    logic        sched_busy, echo_drop, report_drop;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          last_done = -1000;
    int          viol = 0;
    int          n_echo_drop = 0;
    int          n_rpt_drop = 0;
    logic [7:0]  sent_q[$];

    always #5 clk = ~clk;

    uart_tx_sched_if tx_bus();

    uart_tx_sched #(.ECHO_EN(1'b1), .CRLF_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .report_req  (report_req),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .tx          (tx_bus),
        .sched_busy  (sched_busy),
        .echo_drop   (echo_drop),
        .report_drop (report_drop)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pulse_report();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sent_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_quiet(output logic ok);
        int run;
        run = 0;
        ok  = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (!sched_busy && !tx_bus.tx_busy) run++;
            else run = 0;
            if (run >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // TX core model: busy for BYTE_CYC cycles after a start, then a done pulse.
    initial begin
        int  cnt;
        logic prev_start;
        cnt = 0;
        prev_start = 1'b0;
        tx_bus.tx_busy = 1'b0;
        tx_bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tx_bus.tx_done = 1'b0;
            if (tx_bus.tx_start === 1'b1) begin
                if (tx_bus.tx_busy) viol++;
                if (prev_start) viol++;
                if (cyc - last_done < 2) viol++;
                sent_q.push_back(tx_bus.tx_data);
                tx_bus.tx_busy = 1'b1;
                cnt = BYTE_CYC;
            end else if (tx_bus.tx_busy) begin
                cnt--;
                if (cnt == 0) begin
                    tx_bus.tx_busy = 1'b0;
                    tx_bus.tx_done = 1'b1;
                    last_done = cyc;
                end
            end
            prev_start = (tx_bus.tx_start === 1'b1);
            if (echo_drop === 1'b1) n_echo_drop++;
            if (report_drop === 1'b1) n_rpt_drop++;
        end
    end

    initial begin
        logic [7:0] exp_rpt [10];
        logic       ok;
        int         d0;
        exp_rpt = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        rx_data = 8'h00; rx_done = 1'b0; report_req = 1'b0;
        hour = 5'd12; min = 6'd34; sec = 6'd56;

        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_bus.tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_bus.tx_data), 32'h00);
        chk("rst_sched_busy", 32'(sched_busy), 32'h0);
        chk("rst_echo_drop", 32'(echo_drop), 32'h0);
        chk("rst_report_drop", 32'(report_drop), 32'h0);
        rst_n = 1'b1;
        tick();

        // Echo from idle
        sent_q.delete();
        rx_data = 8'h47; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("echo_start_n1", 32'(tx_bus.tx_start), 32'h0);
        tick();
        chk("echo_start_n2", 32'(tx_bus.tx_start), 32'h1);
        chk("echo_data", 32'(tx_bus.tx_data), 32'h47);
        chk("echo_busy", 32'(sched_busy), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_bus.tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("echo_done_seen", 32'(ok), 32'h1);
        chk("echo_busy_at_done", 32'(sched_busy), 32'h1);
        tick();
        chk("echo_busy_after_done", 32'(sched_busy), 32'h0);
        wait_quiet(ok);
        chk("echo_count", 32'(sent_q.size()), 32'd1);

        // Time report 12:34:56
        sent_q.delete();
        pulse_report();
        chk("rpt_start_n1", 32'(tx_bus.tx_start), 32'h0);
        tick();
        chk("rpt_start_n2", 32'(tx_bus.tx_start), 32'h1);
        wait_quiet(ok);
        chk("rpt_quiet", 32'(ok), 32'h1);
        chk("rpt_count", 32'(sent_q.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("rpt_byte%0d", i), 32'(sent_q[i]), 32'(exp_rpt[i]));

        // Snapshot holds and boundary min=63
        sent_q.delete();
        hour = 5'd7; min = 6'd63; sec = 6'd59;
        pulse_report();
        wait_bytes(1, ok);
        chk("snap_first", 32'(ok), 32'h1);
        sec = 6'd0; min = 6'd0;
        wait_quiet(ok);
        chk("snap_count", 32'(sent_q.size()), 32'd10);
        chk("snap_h_tens", 32'(sent_q[0]), 32'h30);
        chk("snap_h_ones", 32'(sent_q[1]), 32'h37);
        chk("snap_m_tens", 32'(sent_q[3]), 32'h36);
        chk("snap_m_ones", 32'(sent_q[4]), 32'h33);
        chk("snap_s_tens", 32'(sent_q[6]), 32'h35);
        chk("snap_s_ones", 32'(sent_q[7]), 32'h39);
        hour = 5'd12; min = 6'd34; sec = 6'd56;

        // Echo and report requested together
        sent_q.delete();
        rx_data = 8'h43; rx_done = 1'b1; report_req = 1'b1;
        tick();
        rx_done = 1'b0; report_req = 1'b0;
        wait_quiet(ok);
        chk("prio_count", 32'(sent_q.size()), 32'd11);
        chk("prio_echo_first", 32'(sent_q[0]), 32'h43);
        chk("prio_frame_byte0", 32'(sent_q[1]), 32'h31);
        chk("prio_frame_last", 32'(sent_q[10]), 32'h0A);

        // Two echoes during a frame
        sent_q.delete();
        d0 = n_echo_drop;
        pulse_report();
        wait_bytes(3, ok);
        chk("ovf_mid_frame", 32'(ok), 32'h1);
        rx_data = 8'h57; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
        rx_data = 8'h44; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        wait_quiet(ok);
        chk("ovf_echo_drops", 32'(n_echo_drop - d0), 32'd1);
        chk("ovf_count", 32'(sent_q.size()), 32'd11);
        chk("ovf_frame_end", 32'(sent_q[9]), 32'h0A);
        chk("ovf_echo_byte", 32'(sent_q[10]), 32'h44);

        // Extra report requests during a frame
        sent_q.delete();
        d0 = n_rpt_drop;
        pulse_report();
        tick();
        pulse_report();
        tick();
        pulse_report();
        wait_quiet(ok);
        chk("rdrop_count", 32'(n_rpt_drop - d0), 32'd1);
        chk("rdrop_bytes", 32'(sent_q.size()), 32'd20);
        chk("rdrop_f2_first", 32'(sent_q[10]), 32'h31);
        chk("rdrop_f2_last", 32'(sent_q[19]), 32'h0A);

        // Reset during the fourth byte
        sent_q.delete();
        pulse_report();
        wait_bytes(4, ok);
        chk("rst_mid_reached", 32'(ok), 32'h1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rstm_tx_start", 32'(tx_bus.tx_start), 32'h0);
        chk("rstm_tx_data", 32'(tx_bus.tx_data), 32'h00);
        chk("rstm_sched_busy", 32'(sched_busy), 32'h0);
        chk("rstm_echo_drop", 32'(echo_drop), 32'h0);
        chk("rstm_report_drop", 32'(report_drop), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("rstm_no_restart", 32'(sent_q.size()), 32'd4);
        chk("protocol_violations", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the stopwatch/watch UART console. Shares the single UART transmitter between two requesters: an echo of every received command byte, and a formatted time report ("HH:MM:SS" plus CR/LF) requested by the control unit. It sits between the UART receiver and command decoder on one side and the UART TX core on the other. It issues one byte at a time under the TX core's busy/done handshake.

## Interface
Parameters:
- ECHO_EN, 1, 1 enables the echo requester; 0 ignores rx_done entirely.
- CRLF_EN, 1, 1 gives a 10-byte report frame (with 0x0D 0x0A); 0 gives an 8-byte frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte, valid in the rx_done cycle.
- rx_done  input  1  one-cycle pulse, received byte available.
- report_req  input  1  one-cycle pulse, request one time report.
- hour  input  5  current hours, 0..31 accepted.
- min  input  6  current minutes, 0..63 accepted.
- sec  input  6  current seconds, 0..63 accepted.
- tx_busy  input  1  TX core is shifting a byte.
- tx_done  input  1  one-cycle pulse at the end of the TX stop bit.
- tx_start  output  1  one-cycle pulse, TX core loads tx_data.
- tx_data  output  8  byte to transmit, held stable until the next tx_start.
- sched_busy  output  1  high whenever the FSM is not in IDLE.
- echo_drop  output  1  one-cycle pulse, a pending echo byte was overwritten.
- report_drop  output  1  one-cycle pulse, a report request was discarded.

## Operation
- Echo buffer:
  - One byte plus echo_valid.
  - rx_done with ECHO_EN=1 loads rx_data and sets echo_valid.
  - If echo_valid is already set and the byte has not been issued, the byte is overwritten and echo_drop pulses.
- Report pending flag:
  - report_req sets report_pend.
  - report_req while report_pend is already set pulses report_drop.
  - A report_req during an active frame sets report_pend, so a second frame follows.
- FSM states:
  - IDLE: if tx_busy=0, echo_valid has priority. Go to ISSUE_ECHO, or else if report_pend go to ISSUE_RPT with idx=0. Entering ISSUE_RPT from IDLE snapshots hour/min/sec and clears report_pend.
  - ISSUE_ECHO: tx_start=1, tx_data=echo byte, clear echo_valid. Go to WAIT.
  - ISSUE_RPT: tx_start=1, tx_data=frame[idx]. Go to WAIT.
  - WAIT: on tx_done, if in a frame and idx < LEN-1, increment idx and go to GAP. Otherwise go to IDLE.
  - GAP: wait for tx_busy=0, then go to ISSUE_RPT.
- Frames are atomic. An echo byte that arrives mid-frame waits until the frame ends.
- Frame bytes, in order:
  - ASCII tens(hour), ones(hour), 0x3A, tens(min), ones(min), 0x3A, tens(sec), ones(sec), then 0x0D, 0x0A if CRLF_EN.
  - ASCII = 0x30 + digit.
  - tens = v/10, ones = v%10, computed on the 6-bit snapshot. For v=63, tens=6 and ones=3.
  - Use compare/subtract only, no divider.
- Simultaneous rx_done and report_req in IDLE: both are latched. The echo is issued first, then the frame.
- Simultaneous rx_done and the ISSUE_ECHO cycle: the new byte is loaded and echo_valid stays set. No drop.
- Reset mid-operation clears the FSM, flags, and snapshot immediately. A byte already started in the TX core is not aborted.

## Timing
- Reset values: tx_start=0, tx_data=8'h00, sched_busy=0, echo_drop=0, report_drop=0. State IDLE, idx=0.
- All outputs are registered.
- Echo latency: rx_done in cycle N sets echo_valid at N+1. tx_start is high in cycle N+2, provided IDLE and tx_busy=0 at N+1.
- Report latency: report_req in cycle N gives the first tx_start at N+2 under the same conditions.
- Inter-byte: tx_done in cycle M gives the next tx_start no earlier than M+2. GAP holds until tx_busy=0.
- tx_start is never asserted while tx_busy=1, and never on two consecutive cycles.
- echo_drop and report_drop pulse in the cycle after the offending input.

## Structure
- Shared package uart_pkg:
  - ASCII constants: colon, CR, LF, zero.
  - FSM state encoding.
  - Frame length localparams: 10 and 8.
- Sub-module bin2ascii2: 6-bit value in, two ASCII digits out, combinational. Instanced three times on the snapshot.

## Test plan
- Echo, idle: rx_done with 0x47 -> tx_start at +2 with tx_data=0x47. Return tx_done -> sched_busy falls 1 cycle later.
- Report: hour=12, min=34, sec=56, report_req, TX model 20-cycle bytes -> bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A, exactly 10 tx_start pulses.
- Snapshot and boundary: report_req with sec=59, change sec to 0 after the first tx_start -> the frame still reports "59". Also min=63 -> bytes 0x36 0x33.
- Priority and overflow:
  - rx_done 0x43 and report_req in the same cycle -> 0x43 sent first, then the frame.
  - Two rx_done (0x57, 0x44) during the frame -> echo_drop pulses once, and only 0x44 is echoed after the 0x0A byte.
- Report drop: three report_req during a frame -> report_drop pulses once and exactly two frames are sent.
- Reset: rst_n low during the 4th byte of a frame -> all outputs at reset values immediately. After release, no further tx_start until a new request.
